smi_frame_arbiter_wrr_x4: RTL and testbench
===========================================

# smi_frame_arbiter_wrr_x4

Four-way, frame-atomic, weighted round-robin arbiter for SMI request streams. It shares one downstream SMI port (memory controller or the next arbitration level) between four upstream frame buffers or assemblers. Once granted, a port keeps the grant for whole frames only. Each port receives up to its configured number of consecutive frames per turn before the grant rotates. It generalises two-way frame arbitration to four requesters with programmable bandwidth shares.

## Interface
- FlitWidth, 4, flit width in bytes (≥4); DataWidth = FlitWidth*8
- WeightA, 1, frames per turn for port A (1..15, 4-bit)
- WeightB, 1, frames per turn for port B (1..15)
- WeightC, 1, frames per turn for port C (1..15)
- WeightD, 1, frames per turn for port D (1..15)

Ports:
- clk  in  1  sole clock; all state on rising edge
- srst  in  1  reset, asynchronous, active-high
- smiInXReady  in  1  upstream flit valid (X = A,B,C,D)
- smiInXEofc  in  8  0 = mid-frame flit; nonzero = final flit and its byte count
- smiInXData  in  DataWidth  upstream flit payload
- smiInXStop  out  1  backpressure to upstream X
- smiOutReady  out  1  downstream flit valid (registered)
- smiOutEofc  out  8  registered eofc
- smiOutData  out  DataWidth  registered payload
- smiOutStop  in  1  downstream backpressure

## Operation
- Transfer on any SMI link: Ready=1 and Stop=0 in the same cycle. Ready/Eofc/Data hold while Stop=1.
- State machine: IDLE, SELECT, FORWARD.
  - IDLE: all smiInXStop=1. If any smiInXReady=1, go to SELECT.
  - SELECT: choose the granted port.
    - If the current port's credit is nonzero and its Ready=1, keep that port.
    - Otherwise, take the first ready port in rotating order starting at (current+1) mod 4, and load its credit with WeightX.
    - If no port is ready, return to IDLE.
    - Otherwise, register the grant and go to FORWARD.
  - FORWARD: the granted port's Stop = !accept; all others Stop=1.
    - accept = !outValid || !smiOutStop, where outValid is the output register's valid bit.
    - On a granted transfer with Eofc≠0: decrement credit (saturating at 0) and go to SELECT.
- Output register: one entry.
  - Loads on a granted transfer.
  - Clears valid on downstream transfer when no new load occurs in the same cycle.
  - Simultaneous load and drain keeps valid=1 with the new flit.
- Flits are forwarded unmodified. No reordering and no interleaving of frames from different ports.
- Credit counter: 4 bits. Grant pointer: 2 bits. Both are reset to credit=0 and pointer=D (3), so port A has first priority after reset.

## Timing
- Reset (asynchronous assert):
  - smiOutReady=0, smiOutEofc=0, smiOutData=0
  - state=IDLE, so all smiInXStop=1
  - Release is synchronous to clk.
- Latency: input transfer to smiOutReady is 1 cycle.
- Arbitration cost:
  - 1 cycle in SELECT between frames.
  - 2 cycles (IDLE+SELECT) from first Ready in idle until Stop falls.
- smiInXStop is combinational from smiOutStop, state and grant. No combinational path from any smiInXReady to any smiInXStop.
- A single-flit frame (Eofc≠0 on the first flit) completes FORWARD in one cycle.
- Ready deasserting mid-frame: grant is held and FORWARD waits indefinitely. No timeout.
- Reset mid-frame: output flit is discarded and the partial frame is lost. The upstream must also be reset.

## Structure
- Package smi_arb_pkg:
  - state enum (IDLE=0, SELECT=1, FORWARD=2)
  - EOFC_MID=8'd0
  - weight width constant (4)
- Sub-module smi_arb_rr_select: combinational 4-way rotating-priority picker. Inputs are the ready vector and last pointer; outputs are grant index and valid. It is reused by later N-way arbiters.
- The top-level holds the FSM, credit counter and output register.

## Test plan
- Reset mid-frame with Ready on A: smiOutReady=0, all Stops=1 while srst=1. A is first granted 2 cycles after release.
- All four ports continuously offer 1-flit frames, weights 1,1,1,1, Stop=0: output order A,B,C,D,A… with one SELECT bubble per frame.
- Weights 3,1,2,1, all saturating with 2-flit frames: per 7-frame cycle the order is AAA B CC D, and no frame is split.
- Only C active, 4-flit frames, weight 1: C is re-granted every frame (rotation finds only C). Throughput is 4 flits per 5 cycles.
- Downstream Stop toggled 1,0 pseudo-randomly during a 5-flit frame from B: all flits appear in order, data unchanged, and B's Stop tracks smiOutStop once the register is full.
- A pauses Ready mid-frame for 10 cycles while D is ready: D stays stopped until A's Eofc≠0 flit, then D is granted.

Source files
------------

// File: rtl/smi_arb_pkg.sv
// Shared types and constants for the SMI frame arbiters.
package smi_arb_pkg;

    localparam int WEIGHT_W  = 4;
    localparam int NUM_PORTS = 4;
    localparam logic [7:0] EOFC_MID = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_FORWARD = 2'd2
    } state_e;

    // Frame credit decrement that stops at zero.
    function automatic logic [WEIGHT_W-1:0] credit_dec(input logic [WEIGHT_W-1:0] c);
        return (c == '0) ? '0 : c - WEIGHT_W'(1);
    endfunction

endpackage

// File: rtl/smi_arb_rr_select.sv
// Combinational 4-way rotating-priority picker: searches from last+1 round to last.
module smi_arb_rr_select
    import smi_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] ready_i,
    input  logic [1:0]           last_ptr_i,
    output logic [1:0]           grant_o,
    output logic                 valid_o
);

    // rot[k] is the ready bit of port (last + 1 + k) mod 4
    logic [NUM_PORTS-1:0] rot;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            assign rot[gi] = ready_i[last_ptr_i + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        grant_o = last_ptr_i;
        valid_o = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                grant_o = last_ptr_i + 2'(k + 1);
            end
        end
    end

endmodule

// File: rtl/smi_frame_arbiter_wrr_x4.sv
// Four-way frame-atomic weighted round-robin arbiter onto one registered SMI port.
module smi_frame_arbiter_wrr_x4
    import smi_arb_pkg::*;
#(
    parameter int FlitWidth = 4,
    parameter int WeightA   = 1,
    parameter int WeightB   = 1,
    parameter int WeightC   = 1,
    parameter int WeightD   = 1
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiInAReady,
    input  logic [7:0]             smiInAEofc,
    input  logic [FlitWidth*8-1:0] smiInAData,
    output logic                   smiInAStop,
    input  logic                   smiInBReady,
    input  logic [7:0]             smiInBEofc,
    input  logic [FlitWidth*8-1:0] smiInBData,
    output logic                   smiInBStop,
    input  logic                   smiInCReady,
    input  logic [7:0]             smiInCEofc,
    input  logic [FlitWidth*8-1:0] smiInCData,
    output logic                   smiInCStop,
    input  logic                   smiInDReady,
    input  logic [7:0]             smiInDEofc,
    input  logic [FlitWidth*8-1:0] smiInDData,
    output logic                   smiInDStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
);

    localparam int DataWidth = FlitWidth * 8;

    logic [NUM_PORTS-1:0] in_ready;
    logic [7:0]           in_eofc  [NUM_PORTS];
    logic [DataWidth-1:0] in_data  [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_stop;
    logic [WEIGHT_W-1:0]  weight   [NUM_PORTS];

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_eofc_q, out_eofc_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;

    logic [1:0]           sel_grant;
    logic                 sel_valid;
    logic                 accept;
    logic                 fwd_xfer;

    assign in_ready = {smiInDReady, smiInCReady, smiInBReady, smiInAReady};
    assign in_eofc[0] = smiInAEofc;
    assign in_eofc[1] = smiInBEofc;
    assign in_eofc[2] = smiInCEofc;
    assign in_eofc[3] = smiInDEofc;
    assign in_data[0] = smiInAData;
    assign in_data[1] = smiInBData;
    assign in_data[2] = smiInCData;
    assign in_data[3] = smiInDData;
    assign weight[0]  = WEIGHT_W'(WeightA);
    assign weight[1]  = WEIGHT_W'(WeightB);
    assign weight[2]  = WEIGHT_W'(WeightC);
    assign weight[3]  = WEIGHT_W'(WeightD);
    assign {smiInDStop, smiInCStop, smiInBStop, smiInAStop} = in_stop;

    smi_arb_rr_select u_rr_select (
        .ready_i    (in_ready),
        .last_ptr_i (grant_q),
        .grant_o    (sel_grant),
        .valid_o    (sel_valid)
    );

    // The one-entry output register can take a flit when empty or draining this cycle.
    assign accept   = !out_valid_q || !smiOutStop;
    assign fwd_xfer = (state_q == ST_FORWARD) && in_ready[grant_q] && accept;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stop
            assign in_stop[gi] = !((state_q == ST_FORWARD) && (grant_q == 2'(gi)) && accept);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        credit_d = credit_q;
        case (state_q)
            ST_IDLE: begin
                if (|in_ready) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if ((credit_q != '0) && in_ready[grant_q]) begin
                    state_d = ST_FORWARD;
                end else if (sel_valid) begin
                    grant_d  = sel_grant;
                    credit_d = weight[sel_grant];
                    state_d  = ST_FORWARD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FORWARD: begin
                if (fwd_xfer && (in_eofc[grant_q] != EOFC_MID)) begin
                    credit_d = credit_dec(credit_q);
                    state_d  = ST_SELECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_eofc_d  = out_eofc_q;
        out_data_d  = out_data_q;
        if (fwd_xfer) begin
            out_valid_d = 1'b1;
            out_eofc_d  = in_eofc[grant_q];
            out_data_d  = in_data[grant_q];
        end else if (out_valid_q && !smiOutStop) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer resets to D so that A wins the first rotation.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'd3;
            credit_q    <= '0;
            out_valid_q <= 1'b0;
            out_eofc_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            credit_q    <= credit_d;
            out_valid_q <= out_valid_d;
            out_eofc_q  <= out_eofc_d;
            out_data_q  <= out_data_d;
        end
    end

    assign smiOutReady = out_valid_q;
    assign smiOutEofc  = out_eofc_q;
    assign smiOutData  = out_data_q;

endmodule

// File: tb/tb_smi_frame_arbiter_wrr_x4.sv
// Directed bench for the 4-way WRR frame arbiter with a cycle-level reference model.
module tb_smi_frame_arbiter_wrr_x4;

    localparam int FW = 4;
    localparam int DW = FW * 8;
    localparam int WA = 3;
    localparam int WB = 1;
    localparam int WC = 2;
    localparam int WD = 1;

    typedef struct packed {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    typedef struct packed {
        int            cyc;
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } rec_t;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic [3:0]    in_ready;
    logic [7:0]    in_eofc [4];
    logic [DW-1:0] in_data [4];
    logic          stop_a, stop_b, stop_c, stop_d;
    logic          smiOutReady;
    logic [7:0]    smiOutEofc;
    logic [DW-1:0] smiOutData;
    logic          out_stop;

    always #5 clk = ~clk;

    smi_frame_arbiter_wrr_x4 #(
        .FlitWidth (FW),
        .WeightA   (WA),
        .WeightB   (WB),
        .WeightC   (WC),
        .WeightD   (WD)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInAReady (in_ready[0]),
        .smiInAEofc  (in_eofc[0]),
        .smiInAData  (in_data[0]),
        .smiInAStop  (stop_a),
        .smiInBReady (in_ready[1]),
        .smiInBEofc  (in_eofc[1]),
        .smiInBData  (in_data[1]),
        .smiInBStop  (stop_b),
        .smiInCReady (in_ready[2]),
        .smiInCEofc  (in_eofc[2]),
        .smiInCData  (in_data[2]),
        .smiInCStop  (stop_c),
        .smiInDReady (in_ready[3]),
        .smiInDEofc  (in_eofc[3]),
        .smiInDData  (in_data[3]),
        .smiInDStop  (stop_d),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (out_stop)
    );

    // Upstream sources: per-port flit FIFOs
    flit_t src_mem [4][128];
    int    src_head [4];
    int    src_tail [4];
    int    pops [4];
    logic [3:0] pause;
    bit    rand_stop;

    rec_t  rec_q [$];
    int    cyc;
    logic [3:0] cap_stop;
    logic [3:0] cap_xin;

    int errors = 0;
    int checks = 0;

    // Reference model state: phase 0=idle 1=choose 2=pass
    int            m_phase, m_owner, m_credit;
    logic          m_ov;
    logic [7:0]    m_oe;
    logic [DW-1:0] m_od;

    function automatic int weight_of(input int p);
        case (p)
            0: return WA;
            1: return WB;
            2: return WC;
            default: return WD;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int x = 0; x < 4; x++) begin
            if (src_head[x] != src_tail[x]) begin
                in_ready[x] = !pause[x];
                in_eofc[x]  = src_mem[x][src_head[x]].eofc;
                in_data[x]  = src_mem[x][src_head[x]].data;
            end else begin
                in_ready[x] = 1'b0;
                in_eofc[x]  = 8'd0;
                in_data[x]  = '0;
            end
        end
    endtask

    task automatic add_frame(input int port, input int fid, input int nflits);
        flit_t f;
        for (int i = 0; i < nflits; i++) begin
            f.eofc = (i == nflits - 1) ? 8'(FW) : 8'd0;
            f.data = {8'(port), 8'(fid), 8'(i), 8'h5A};
            src_mem[port][src_tail[port]] = f;
            src_tail[port]++;
        end
        drive_inputs();
    endtask

    function automatic int pending();
        int s = 0;
        for (int x = 0; x < 4; x++) s += src_tail[x] - src_head[x];
        return s;
    endfunction

    // One clock: compare at negedge, advance model, then update sources after posedge.
    task automatic tick();
        logic [3:0] st;
        logic [3:0] exp_stop;
        logic       acc;
        logic       load;
        int         found;
        rec_t       r;
        @(negedge clk);
        st = {stop_d, stop_c, stop_b, stop_a};
        cap_stop = st;
        cap_xin  = 4'd0;
        if (srst) begin
            chk("rst_in_stop", st, 4'hF);
            chk("rst_out_ready", smiOutReady, 1'b0);
            chk("rst_out_eofc", smiOutEofc, 8'd0);
            chk("rst_out_data", smiOutData, '0);
            m_phase = 0; m_owner = 3; m_credit = 0;
            m_ov = 1'b0; m_oe = 8'd0; m_od = '0;
        end else begin
            acc = !m_ov || !out_stop;
            exp_stop = 4'hF;
            if (m_phase == 2 && acc) exp_stop[m_owner] = 1'b0;
            chk("in_stop", st, exp_stop);
            chk("out_ready", smiOutReady, m_ov);
            if (m_ov) begin
                chk("out_eofc", smiOutEofc, m_oe);
                chk("out_data", smiOutData, m_od);
            end
            cap_xin = in_ready & ~st;
            if (smiOutReady && !out_stop) begin
                r.cyc = cyc; r.eofc = smiOutEofc; r.data = smiOutData;
                rec_q.push_back(r);
            end
            load = (m_phase == 2) && in_ready[m_owner] && acc;
            if (load) begin
                m_ov = 1'b1; m_oe = in_eofc[m_owner]; m_od = in_data[m_owner];
            end else if (m_ov && !out_stop) begin
                m_ov = 1'b0;
            end
            case (m_phase)
                0: if (|in_ready) m_phase = 1;
                1: begin
                    if (m_credit > 0 && in_ready[m_owner]) begin
                        m_phase = 2;
                    end else begin
                        found = -1;
                        for (int k = 1; k <= 4; k++)
                            if (found < 0 && in_ready[(m_owner + k) % 4]) found = (m_owner + k) % 4;
                        if (found < 0) m_phase = 0;
                        else begin
                            m_owner = found; m_credit = weight_of(found); m_phase = 2;
                        end
                    end
                end
                default: if (load && in_eofc[m_owner] != 8'd0) begin
                    if (m_credit > 0) m_credit--;
                    m_phase = 1;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int x = 0; x < 4; x++) begin
            if (cap_xin[x]) begin
                src_head[x]++;
                pops[x]++;
            end
        end
        if (rand_stop) out_stop = ($urandom_range(0, 1) == 1);
        drive_inputs();
    endtask

    task automatic clear_sources();
        for (int x = 0; x < 4; x++) begin
            src_head[x] = 0; src_tail[x] = 0; pops[x] = 0;
        end
        pause = 4'd0;
        rand_stop = 1'b0;
        out_stop = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        srst = 1'b1;
        clear_sources();
        tick();
        tick();
        srst = 1'b0;
        rec_q.delete();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, pending(), 0);
        rand_stop = 1'b0;
        out_stop = 1'b0;
        repeat (6) tick();
    endtask

    function automatic string frame_order();
        string s = "";
        foreach (rec_q[i])
            if (rec_q[i].eofc != 8'd0) s = $sformatf("%s%c", s, 8'h41 + rec_q[i].data[31:24]);
        return s;
    endfunction

    // Each frame must be contiguous: same port throughout, flit indices 0,1,2...
    function automatic int frames_intact();
        int idx = 0;
        int cur = 0;
        foreach (rec_q[i]) begin
            if (idx == 0) cur = int'(rec_q[i].data[31:24]);
            if (int'(rec_q[i].data[31:24]) != cur || int'(rec_q[i].data[15:8]) != idx) return 0;
            idx = (rec_q[i].eofc != 8'd0) ? 0 : idx + 1;
        end
        return 1;
    endfunction

    initial begin
        int n;
        int d_low;
        cyc = 0;
        in_ready = 4'd0;
        clear_sources();

        // Reset mid-frame with A active, then first grant latency after release
        do_reset();
        add_frame(0, 0, 4);
        n = 0;
        while (pops[0] < 2 && n < 50) begin tick(); n++; end
        chk("t1_midframe_reached", pops[0], 2);
        srst = 1'b1;
        clear_sources();
        add_frame(0, 1, 3);
        repeat (3) tick();
        srst = 1'b0;
        rec_q.delete();
        n = 0;
        tick();
        while (cap_stop[0] && n < 8) begin n++; tick(); end
        chk("t1_grant_latency", n, 2);
        run_until_idle("t1", 200);
        chk("t1_flits", rec_q.size(), 3);
        if (rec_q.size() > 0) chk("t1_first_fid", rec_q[0].data[23:16], 8'd1);
        chk_str("t1_order", frame_order(), "A");
        $display("t1 reset mid-frame: order=%s flits=%0d", frame_order(), rec_q.size());

        // Single-flit frames from all ports, weights 3,1,2,1
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int f = 0; f < 4; f++) add_frame(p, f, 1);
        run_until_idle("t2", 400);
        chk_str("t2_order", frame_order(), "AAABCCDABCCDBDBD");
        chk("t2_integrity", frames_intact(), 1);
        if (rec_q.size() > 1) chk("t2_bubble", rec_q[1].cyc - rec_q[0].cyc, 2);
        $display("t2 1-flit frames: order=%s", frame_order());

        // Saturating 2-flit frames, two full weight cycles
        do_reset();
        for (int f = 0; f < 6; f++) add_frame(0, f, 2);
        for (int f = 0; f < 2; f++) add_frame(1, f, 2);
        for (int f = 0; f < 4; f++) add_frame(2, f, 2);
        for (int f = 0; f < 2; f++) add_frame(3, f, 2);
        run_until_idle("t3", 600);
        chk_str("t3_order", frame_order(), "AAABCCDAAABCCD");
        chk("t3_integrity", frames_intact(), 1);
        $display("t3 2-flit frames: order=%s", frame_order());

        // Only C active with 4-flit frames
        do_reset();
        for (int f = 0; f < 3; f++) add_frame(2, f, 4);
        run_until_idle("t4", 300);
        chk_str("t4_order", frame_order(), "CCC");
        chk("t4_flits", rec_q.size(), 12);
        if (rec_q.size() == 12) chk("t4_span", rec_q[11].cyc - rec_q[0].cyc, 13);
        $display("t4 C only: order=%s flits=%0d", frame_order(), rec_q.size());

        // B 5-flit frame under random downstream stop
        do_reset();
        rand_stop = 1'b1;
        add_frame(1, 7, 5);
        run_until_idle("t5", 300);
        chk_str("t5_order", frame_order(), "B");
        chk("t5_flits", rec_q.size(), 5);
        chk("t5_integrity", frames_intact(), 1);
        for (int i = 0; i < rec_q.size() && i < 5; i++)
            chk("t5_data", rec_q[i].data, {8'd1, 8'd7, 8'(i), 8'h5A});
        $display("t5 B under stop: order=%s flits=%0d", frame_order(), rec_q.size());

        // A pauses mid-frame while D waits
        do_reset();
        add_frame(0, 0, 4);
        add_frame(3, 0, 1);
        n = 0;
        while (pops[0] < 2 && n < 50) begin tick(); n++; end
        chk("t6_midframe_reached", pops[0], 2);
        pause[0] = 1'b1;
        drive_inputs();
        d_low = 0;
        repeat (10) begin
            tick();
            if (!cap_stop[3]) d_low++;
        end
        chk("t6_d_held", d_low, 0);
        pause[0] = 1'b0;
        drive_inputs();
        run_until_idle("t6", 200);
        chk_str("t6_order", frame_order(), "AD");
        chk("t6_integrity", frames_intact(), 1);
        $display("t6 A paused: order=%s", frame_order());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
